// File: rtl/fetch_stage_if.sv
// Request/response bundle between the fetch stage and the fetch buffer.
// master: the fetch stage side (drives requests, receives responses).
// slave: the fetch buffer side.
interface fetch_stage_if;
    // request to fetch buffer
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_spec;
    logic        mem_fence;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    // response from fetch buffer
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_instr, mem_spec, mem_fence, mem_mode,
               mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_error, mem_ready
    );

    modport slave (
        input  mem_valid, mem_instr, mem_spec, mem_fence, mem_mode,
               mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_error, mem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one fetch-buffer read at a
// time, and presents one registered instruction per handshake to decode.
//
// state | meaning
// SPEC  | speculative restart of the fetch buffer, no request issued
// RUN   | fetching: issue when slot will be free, capture responses
// HALT  | access fault captured; wait for a redirect
module fetch_stage #(
    parameter logic [31:0] reset_pc = 32'h0
) (
    input  logic               clock,
    input  logic               reset,
    fetch_stage_if.master      fb,
    input  logic               redir_valid,
    input  logic [31:0]        redir_addr,
    input  logic [1:0]         redir_mode,
    input  logic               stall,
    output logic               inst_valid,
    output logic [31:0]        inst_pc,
    output logic [31:0]        inst_data,
    output logic               inst_comp,
    output logic               inst_error
);

    typedef enum logic [1:0] {
        SPEC = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [1:0] M_MODE = 2'b11;

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  mode;
    logic        pend;

    logic        issue;
    logic        accept;
    logic        handshake;
    logic        comp;

    // Request only when nothing is outstanding and the slot is free or
    // draining this cycle, so a response can never land on a stalled slot.
    always_comb begin
        issue     = (state == RUN) && !pend && (!inst_valid || !stall);
        accept    = (state == RUN) && fb.mem_ready && (pend || issue);
        handshake = inst_valid && !stall;
        comp      = (fb.mem_rdata[1:0] != 2'b11);
    end

    // Fetch-buffer request; a redirect overrides everything except reset.
    always_comb begin
        fb.mem_valid = 1'b0;
        fb.mem_spec  = 1'b0;
        fb.mem_addr  = pc;
        fb.mem_mode  = mode;
        fb.mem_instr = 1'b1;
        fb.mem_fence = 1'b0;
        fb.mem_wdata = 32'h0;
        fb.mem_wstrb = 4'h0;
        if (reset) begin
            fb.mem_valid = 1'b0;
            fb.mem_spec  = 1'b0;
        end else if (redir_valid) begin
            fb.mem_spec = 1'b1;
            fb.mem_addr = redir_addr & ~32'h3;
            fb.mem_mode = redir_mode;
        end else begin
            case (state)
                SPEC:    fb.mem_spec  = 1'b1;
                RUN:     fb.mem_valid = issue;
                default: fb.mem_valid = 1'b0;
            endcase
        end
    end

    // FSM, PC and instruction slot; redirect squashes any same-cycle response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SPEC;
            pc         <= reset_pc;
            mode       <= M_MODE;
            pend       <= 1'b0;
            inst_valid <= 1'b0;
            inst_pc    <= 32'h0;
            inst_data  <= 32'h0;
            inst_comp  <= 1'b0;
            inst_error <= 1'b0;
        end else if (redir_valid) begin
            state      <= RUN;
            pc         <= redir_addr & ~32'h1;
            mode       <= redir_mode;
            pend       <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                SPEC: state <= RUN;
                RUN: begin
                    if (accept) begin
                        inst_valid <= 1'b1;
                        inst_pc    <= pc;
                        inst_data  <= comp ? {16'h0, fb.mem_rdata[15:0]} : fb.mem_rdata;
                        inst_comp  <= comp;
                        inst_error <= fb.mem_error;
                        pend       <= 1'b0;
                        if (fb.mem_error)
                            state <= HALT;
                        else
                            pc <= pc + (comp ? 32'd2 : 32'd4);
                    end else begin
                        if (issue)
                            pend <= 1'b1;
                        if (handshake)
                            inst_valid <= 1'b0;
                    end
                end
                HALT: begin
                    if (handshake)
                        inst_valid <= 1'b0;
                end
                default: state <= SPEC;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: request-side outputs are checked directly,
// presented instructions are checked against a scoreboard filled when each
// fetch-buffer response is driven.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        comp;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic [1:0]  redir_mode;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_comp;
    logic        inst_error;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    fetch_stage_if fb ();

    fetch_stage #(.reset_pc(32'h8000_0000)) dut (
        .clock      (clock),
        .reset      (reset),
        .fb         (fb),
        .redir_valid(redir_valid),
        .redir_addr (redir_addr),
        .redir_mode (redir_mode),
        .stall      (stall),
        .inst_valid (inst_valid),
        .inst_pc    (inst_pc),
        .inst_data  (inst_data),
        .inst_comp  (inst_comp),
        .inst_error (inst_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err, input logic push);
        exp_t e;
        fb.mem_ready = 1'b1;
        fb.mem_rdata = rdata;
        fb.mem_error = err;
        if (push) begin
            e.pc   = fb.mem_addr;
            e.data = (rdata[1:0] != 2'b11) ? {16'h0, rdata[15:0]} : rdata;
            e.comp = (rdata[1:0] != 2'b11);
            e.err  = err;
            sb.push_back(e);
        end
    endtask

    // Settle, score any handshake happening this cycle, then advance one clock.
    task automatic clk_step();
        exp_t e;
        #1;
        if (inst_valid && !stall && !redir_valid && !reset) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_handshake", {31'h0, inst_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_pc",   inst_pc,             e.pc);
                chk("sb_data", inst_data,           e.data);
                chk("sb_comp", {31'h0, inst_comp},  {31'h0, e.comp});
                chk("sb_err",  {31'h0, inst_error}, {31'h0, e.err});
            end
        end
        @(posedge clock);
        #1;
        fb.mem_ready = 1'b0;
        fb.mem_error = 1'b0;
        fb.mem_rdata = 32'h0;
        redir_valid  = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        redir_valid  = 1'b0;
        redir_addr   = 32'h0;
        redir_mode   = 2'b00;
        stall        = 1'b0;
        fb.mem_ready = 1'b0;
        fb.mem_error = 1'b0;
        fb.mem_rdata = 32'h0;

        // reset state
        repeat (3) @(posedge clock);
        #2;
        chk("rst_valid",      {31'h0, fb.mem_valid}, 32'h0);
        chk("rst_spec",       {31'h0, fb.mem_spec},  32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid},   32'h0);
        chk("rst_inst_pc",    inst_pc,               32'h0);
        chk("rst_inst_data",  inst_data,             32'h0);

        // 1. reset sequence
        reset = 1'b0;
        #1;
        chk("t1_spec",   {31'h0, fb.mem_spec},  32'h1);
        chk("t1_valid0", {31'h0, fb.mem_valid}, 32'h0);
        chk("t1_addr0",  fb.mem_addr,           32'h8000_0000);
        clk_step();
        chk("t1_valid1", {31'h0, fb.mem_valid}, 32'h1);
        chk("t1_spec1",  {31'h0, fb.mem_spec},  32'h0);
        chk("t1_addr1",  fb.mem_addr,           32'h8000_0000);
        chk("t1_mode",   {30'h0, fb.mem_mode},  32'h3);
        chk("t1_instr",  {31'h0, fb.mem_instr}, 32'h1);
        respond(32'h0000_0513, 1'b0, 1'b1);
        clk_step();
        chk("t1_ivalid", {31'h0, inst_valid},   32'h1);
        chk("t1_icomp",  {31'h0, inst_comp},    32'h0);
        chk("t1_next",   fb.mem_addr,           32'h8000_0004);
        chk("t1_nvalid", {31'h0, fb.mem_valid}, 32'h1);
        clk_step();
        chk("t1_drain",  {31'h0, inst_valid},   32'h0);
        chk("t1_pend",   {31'h0, fb.mem_valid}, 32'h0);

        // 2. compressed stream from pc 0
        redir_valid = 1'b1; redir_addr = 32'h0; redir_mode = 2'b11;
        #1;
        chk("t2_spec", {31'h0, fb.mem_spec}, 32'h1);
        clk_step();
        chk("t2_addr0", fb.mem_addr, 32'h0);
        respond(32'h0000_4501, 1'b0, 1'b1);
        clk_step();
        chk("t2_addr2", fb.mem_addr, 32'h2);
        chk("t2_valid2", {31'h0, fb.mem_valid}, 32'h1);
        respond(32'h00A0_0093, 1'b0, 1'b1);
        clk_step();
        chk("t2_addr6", fb.mem_addr, 32'h6);

        // 3. stall holds slot and blocks requests
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_nvalid", {31'h0, fb.mem_valid}, 32'h0);
            chk("t3_ivalid", {31'h0, inst_valid},   32'h1);
            chk("t3_pc",     inst_pc,               32'h2);
            chk("t3_data",   inst_data,             32'h00A0_0093);
            clk_step();
        end
        stall = 1'b0;
        #1;
        chk("t3_release", {31'h0, fb.mem_valid}, 32'h1);
        chk("t3_raddr",   fb.mem_addr,           32'h6);
        clk_step();

        // 4. redirect while pending, with a stale response in the same cycle
        redir_valid = 1'b1; redir_addr = 32'h0000_1002; redir_mode = 2'b00;
        respond(32'hDEAD_BEEF, 1'b0, 1'b0);
        #1;
        chk("t4_spec",  {31'h0, fb.mem_spec},  32'h1);
        chk("t4_addr",  fb.mem_addr,           32'h0000_1000);
        chk("t4_valid", {31'h0, fb.mem_valid}, 32'h0);
        chk("t4_mode",  {30'h0, fb.mem_mode},  32'h0);
        clk_step();
        chk("t4_ivalid", {31'h0, inst_valid},   32'h0);
        chk("t4_next",   fb.mem_addr,           32'h0000_1002);
        chk("t4_nvalid", {31'h0, fb.mem_valid}, 32'h1);
        clk_step();
        chk("t4_stale", {31'h0, inst_valid}, 32'h0);

        // 5. access fault halts fetching until redirected
        redir_valid = 1'b1; redir_addr = 32'h40; redir_mode = 2'b11;
        clk_step();
        chk("t5_addr", fb.mem_addr, 32'h40);
        respond(32'h0000_0013, 1'b1, 1'b1);
        clk_step();
        chk("t5_ierr",   {31'h0, inst_error},   32'h1);
        chk("t5_halt",   {31'h0, fb.mem_valid}, 32'h0);
        clk_step();
        for (int i = 0; i < 3; i++) begin
            chk("t5_quiet",  {31'h0, fb.mem_valid}, 32'h0);
            chk("t5_empty",  {31'h0, inst_valid},   32'h0);
            clk_step();
        end
        redir_valid = 1'b1; redir_addr = 32'h100;
        clk_step();
        chk("t5_resume", fb.mem_addr,           32'h100);
        chk("t5_rvalid", {31'h0, fb.mem_valid}, 32'h1);
        respond(32'h0000_0013, 1'b0, 1'b1);
        clk_step();
        chk("t5_next", fb.mem_addr, 32'h104);
        clk_step();

        // 6. pc wraps around
        redir_valid = 1'b1; redir_addr = 32'hFFFF_FFFC;
        clk_step();
        chk("t6_addr", fb.mem_addr, 32'hFFFF_FFFC);
        respond(32'h0010_0073, 1'b0, 1'b1);
        clk_step();
        chk("t6_wrap",  fb.mem_addr,           32'h0);
        chk("t6_valid", {31'h0, fb.mem_valid}, 32'h1);

        // redirect in the same cycle as a handshake squashes it
        respond(32'h0000_4501, 1'b0, 1'b0);
        clk_step();
        chk("sq_ivalid", {31'h0, inst_valid}, 32'h1);
        chk("sq_pc",     inst_pc,             32'h0);
        chk("sq_comp",   {31'h0, inst_comp},  32'h1);
        redir_valid = 1'b1; redir_addr = 32'h200;
        clk_step();
        chk("sq_cleared", {31'h0, inst_valid}, 32'h0);
        chk("sq_addr",    fb.mem_addr,         32'h200);

        // reset wins over a simultaneous redirect
        reset = 1'b1; redir_valid = 1'b1; redir_addr = 32'h300;
        #1;
        chk("rr_spec",  {31'h0, fb.mem_spec},  32'h0);
        chk("rr_valid", {31'h0, fb.mem_valid}, 32'h0);
        clk_step();
        reset = 1'b0;
        #1;
        chk("rr_restart", fb.mem_addr,          32'h8000_0000);
        chk("rr_spec1",   {31'h0, fb.mem_spec}, 32'h1);
        clk_step();

        chk("sb_empty", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly downstream of the fetch buffer. It owns the program counter and issues one read at a time into the fetch buffer's request port. It steps the PC by 2 for compressed instructions and by 4 otherwise, and presents one registered instruction per handshake to decode. Redirects from execute/trap logic are converted into fetch-buffer speculative restarts.

## Interface
Parameters:
- reset_pc, 32'h0, PC loaded on reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fb_in  out  mem_in_type  request to fetch buffer.
  - Driven fields: mem_valid, mem_spec, mem_mode[1:0], mem_addr[31:0].
  - Constants: mem_instr=1, mem_fence=0, mem_wdata=0, mem_wstrb=0.
- fb_out  in  mem_out_type  fetch buffer response; mem_rdata[31:0], mem_error, mem_ready used.
- redir_valid  in  1  redirect request, single-cycle pulse.
- redir_addr  in  32  redirect target; bit 0 ignored.
- redir_mode  in  2  privilege mode for fetches after the redirect.
- stall  in  1  decode cannot accept the instruction presented this cycle.
- inst_valid  out  1  instruction register holds a valid instruction.
- inst_pc  out  32  PC of the presented instruction.
- inst_data  out  32  instruction; upper 16 bits are zero when compressed.
- inst_comp  out  1  presented instruction is 16-bit.
- inst_error  out  1  fetch access fault for this PC.

## Operation
Registers:
- state ∈ {SPEC, RUN, HALT}
- pc[31:0], mode[1:0], pend (one request outstanding)
- Output slot: inst_* registers.

States:
- **SPEC** (entered from reset)
  - Drive mem_spec=1, mem_valid=0, mem_addr=pc, mem_mode=mode.
  - Next state: RUN.
- **RUN**
  - Issue: mem_valid=1 and mem_addr=pc when pend=0 and (inst_valid=0 or stall=0). Issuing sets pend unless mem_ready is already high in the same cycle.
  - On mem_ready=1:
    - Load slot: inst_pc=pc, inst_error=mem_error.
    - comp = (mem_rdata[1:0]!=2'b11).
    - inst_data = comp ? {16'h0, rdata[15:0]} : rdata.
    - pc += comp ? 2 : 4, modulo 2^32.
    - Clear pend; set inst_valid=1.
    - If mem_error=1, go to HALT and do not advance pc.
  - Slot drain: a handshake occurs when inst_valid=1 and stall=0. It clears inst_valid unless a new mem_ready refills the slot the same cycle.
- **HALT**
  - No requests. The slot is held until drained.
  - Leaves only on redirect.

Redirect (any state, highest priority):
- Drive mem_spec=1, mem_addr={redir_addr[31:2],2'b00}, mem_mode=redir_mode, mem_valid=0.
- Update registers: pc={redir_addr[31:1],1'b0}, mode=redir_mode.
- Clear pend and inst_valid. Ignore any mem_ready that cycle.
- Next state: RUN.
- pc keeps bit 1, so a halfword target is fetched correctly: mem_addr[1] selects the fetch buffer's compressed-alignment path.

Invariants:
- At most one request outstanding.
- A mem_ready never arrives while the slot is full and stalled: requests are only issued when the slot will be free.

## Timing
- Reset values:
  - state=SPEC, pc=reset_pc, mode=m_mode, pend=0.
  - inst_valid=0, inst_pc=0, inst_data=0, inst_comp=0, inst_error=0.
  - While reset=1: mem_valid=0, mem_spec=0.
- First cycle after reset: mem_spec=1. First mem_valid is on the second cycle.
- mem_ready in cycle t → inst_valid=1 in t+1. Next request may issue in t+1 if stall=0.
- Back-to-back throughput is one instruction per cycle when the fetch buffer answers mem_ready in the same cycle as mem_valid.
- All fb_in fields are combinational from registers plus redir_*, stall and fb_out.mem_ready. inst_* are pure registers.
- Simultaneous redirect and handshake: the redirect wins. The slot is cleared and the consumer must treat that cycle's handshake as squashed.
- Simultaneous redirect and reset: reset wins.
- Reset mid-request: pend cleared, and SPEC flushes the fetch buffer.

## Test plan
1. **Reset sequence.** reset_pc=0x80000000, release reset.
   - Cycle 1: mem_spec=1, mem_addr=0x80000000.
   - Cycle 2: mem_valid=1.
   - Respond rdata=0x00000513 → inst_valid=1, inst_pc=0x80000000, inst_comp=0, next mem_addr=0x80000004.
2. **Compressed stream.** Responses 0x4501, then 0x00A00093.
   - inst_pc sequence 0x0, 0x2; inst_comp 1 then 0; next pc=0x6.
3. **Stall.** Hold stall=1 for 3 cycles with inst_valid=1.
   - inst_* stable, mem_valid=0 throughout.
   - On stall=0: handshake, and mem_valid=1 in the same cycle.
4. **Redirect.** Pulse redir_valid with redir_addr=0x00001002 while pend=1.
   - mem_spec=1, mem_addr=0x00001000; next cycle inst_valid=0.
   - Next request mem_addr=0x00001002.
   - A stale mem_ready arriving in the redirect cycle is not captured.
5. **Fault.** Respond mem_error=1 at pc=0x40.
   - inst_error=1, inst_pc=0x40, state HALT, no mem_valid after the drain.
   - redir_valid to 0x100 resumes fetching at 0x100.
6. **Wrap-around.** Redirect to 0xFFFFFFFC, respond with a 32-bit instruction.
   - Next mem_addr=0x00000000.
